// File: rtl/inert_seq_pkg.sv
// Shared types and SPI command tables for the inertial sequencer.
package inert_seq_pkg;

    typedef enum logic [2:0] {
        BOOT,
        INIT_WR,
        INIT_WT,
        IDLE,
        RD_WR,
        RD_WT,
        VALID
    } state_t;

    // Element [0] is issued first.
    localparam logic [3:0][15:0] INIT_CMD = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};
    localparam logic [3:0][15:0] RD_CMD   = {16'hAD00, 16'hAC00, 16'hA300, 16'hA200};

endpackage

// File: rtl/inert_seq_int_sync.sv
// Two-flop synchronizer for the IMU data-ready level.
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= i_async;
            r_ff2 <= r_ff1;
        end
    end

    assign o_sync = r_ff2;

endmodule

// File: rtl/inert_seq.sv
// IMU sequencer: boot delay, init writes, then a 4-byte pitch-rate/AZ read per data-ready.
module inert_seq
    import inert_seq_pkg::*;
#(
    parameter int unsigned TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [7:0]  rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [TMR_W-1:0] r_tmr;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [3:0][7:0]  r_byte;
    logic             r_wrt;
    logic [15:0]      r_cmd;
    logic [15:0]      w_cmd_nxt;
    logic             r_vld;
    logic             w_cap;
    logic             w_int;

    int_sync u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (INT),
        .o_sync  (w_int)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_idx_nxt   = r_idx;
        w_cap       = 1'b0;
        unique case (r_state)
            BOOT: begin
                if (r_tmr == '1) begin
                    w_nxt_state = INIT_WR;
                    w_idx_nxt   = '0;
                end
            end
            INIT_WR: w_nxt_state = INIT_WT;
            INIT_WT: begin
                if (done) begin
                    if (r_idx == 2'd3) begin
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_state = INIT_WR;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (w_int) begin
                    w_nxt_state = RD_WR;
                    w_idx_nxt   = '0;
                end
            end
            RD_WR: w_nxt_state = RD_WT;
            RD_WT: begin
                if (done) begin
                    w_cap = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_nxt_state = VALID;
                    end else begin
                        w_nxt_state = RD_WR;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
            end
            VALID:   w_nxt_state = IDLE;
            default: w_nxt_state = BOOT;
        endcase
    end

    // cmd is loaded on entry to a *_WR state so it is stable from wrt until done.
    always_comb begin
        w_cmd_nxt = r_cmd;
        if (w_nxt_state == INIT_WR) begin
            w_cmd_nxt = INIT_CMD[w_idx_nxt];
        end else if (w_nxt_state == RD_WR) begin
            w_cmd_nxt = RD_CMD[w_idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_tmr   <= '0;
            r_idx   <= '0;
            r_byte  <= '0;
            r_wrt   <= 1'b0;
            r_cmd   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (r_state == BOOT && r_tmr != '1) begin
                r_tmr <= r_tmr + 1'b1;
            end
            r_idx <= w_idx_nxt;
            if (w_cap) begin
                r_byte[r_idx] <= rd_data;
            end
            r_wrt <= (w_nxt_state == INIT_WR) || (w_nxt_state == RD_WR);
            r_cmd <= w_cmd_nxt;
            r_vld <= (w_nxt_state == VALID);
        end
    end

    assign wrt     = r_wrt;
    assign cmd     = r_cmd;
    assign vld     = r_vld;
    assign ptch_rt = {r_byte[1], r_byte[0]};
    assign AZ      = {r_byte[3], r_byte[2]};

endmodule

// File: tb/tb_inert_seq.sv
// Self-checking bench for inert_seq: SPI responder model, vld scoreboard, table + random reads.
module tb_inert_seq;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        wrt;
    logic        vld;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    inert_seq #(.TMR_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] cmd_log[$];
    int          wrt_cyc[$];
    logic [7:0]  rd_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'h0;
    int          vld_cnt = 0;
    int          last_vld_cyc = 0;
    int          spur_n = 0;
    int          rel_cyc = 0;
    bit          aborted = 1'b1;

    logic [15:0] init_tab[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [7:0]  rd_addr[4]  = '{8'hA2, 8'hA3, 8'hAC, 8'hAD};

    typedef struct {
        logic [3:0][7:0] b;
        logic [15:0]     p;
        logic [15:0]     a;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Reference: bytes arrive lo/hi for pitch then lo/hi for AZ; outputs are plain 16-bit words.
    function automatic logic [31:0] model(input logic [3:0][7:0] b);
        int p;
        int a;
        p = b[1] * 256 + b[0];
        a = b[3] * 256 + b[2];
        return {p[15:0], a[15:0]};
    endfunction

    // SPI master model: done LAT clks after wrt, read bytes from rd_q.
    initial begin
        int cnt;
        bit busy;
        logic [15:0] cur;
        cnt = 0;
        busy = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    done = 1'b1;
                    if (cur[15] && rd_q.size() > 0) rd_data = rd_q.pop_front();
                    else rd_data = 8'h5A;
                    if (!aborted) chk("cmd_hold", cmd, cur);
                end
            end else if (spur_n > 0) begin
                done = 1'b1;
                rd_data = 8'($urandom());
                spur_n--;
            end
            if (wrt) begin
                chk("wrt_while_busy", {31'd0, busy}, 32'd0);
                busy = 1'b1;
                cnt = LAT;
                cur = cmd;
                aborted = 1'b0;
                cmd_log.push_back(cmd);
                wrt_cyc.push_back(cyc);
            end
        end
    end

    // vld scoreboard
    initial begin
        logic prev;
        logic [31:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (vld === 1'b1) begin
                chk("vld_width", {31'd0, prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL vld_unexpected: got vld=1 expected no vld");
                end else begin
                    e = exp_q.pop_front();
                    chk("vld_ptch", ptch_rt, e[31:16]);
                    chk("vld_az", AZ, e[15:0]);
                end
                vld_cnt++;
                last_vld_cyc = cyc;
            end
            prev = vld;
        end
    end

    task automatic push_read(input logic [3:0][7:0] b, input logic [31:0] e);
        for (int i = 0; i < 4; i++) rd_q.push_back(b[i]);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic read_cmds_ok(input int base);
        for (int i = 0; i < 4; i++) begin
            if (base + i < cmd_log.size()) chk("rd_cmd", cmd_log[base+i], {rd_addr[i], 8'h00});
            else timeout("rd_cmd_missing");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        INT = 1'b0;
        aborted = 1'b1;
        rd_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_wrt", {31'd0, wrt}, 32'd0);
        chk("rst_vld", {31'd0, vld}, 32'd0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_ptch", ptch_rt, 16'h0000);
        chk("rst_az", AZ, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic check_init(input int base);
        int t;
        t = 0;
        while (cmd_log.size() < base + 4 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            timeout("init_wrts");
        end else begin
            chk("boot_delay", wrt_cyc[base] - rel_cyc, 16);
            for (int i = 0; i < 4; i++) chk("init_cmd", cmd_log[base+i], init_tab[i]);
        end
    endtask

    task automatic run_read(input logic [3:0][7:0] b, input logic [31:0] e);
        int base;
        int n;
        int t;
        base = cmd_log.size();
        n = vld_cnt;
        push_read(b, e);
        INT = 1'b1;
        t = 0;
        while (cmd_log.size() <= base && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("rd_start");
        INT = 1'b0;
        t = 0;
        while (vld_cnt <= n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("rd_vld");
        read_cmds_ok(base);
    endtask

    initial begin
        int t;
        int base;
        int n;
        int w;
        logic [3:0][7:0] b;

        vt[0].b = {8'hAB, 8'hCD, 8'h12, 8'h34}; vt[0].p = 16'h1234; vt[0].a = 16'hABCD;
        vt[1].b = {8'hFF, 8'hFF, 8'h80, 8'h00}; vt[1].p = 16'h8000; vt[1].a = 16'hFFFF;
        vt[2].b = {8'h00, 8'h01, 8'h7F, 8'hFF}; vt[2].p = 16'h7FFF; vt[2].a = 16'h0001;
        vt[3].b = {8'h3C, 8'hC3, 8'hA5, 8'h5A}; vt[3].p = 16'hA55A; vt[3].a = 16'h3CC3;

        // Boot, init, INT raised during init
        do_reset();
        t = 0;
        while (cmd_log.size() < 1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) timeout("first_wrt");
        b = $urandom();
        push_read(b, model(b));
        INT = 1'b1;
        check_init(0);
        t = 0;
        while (cmd_log.size() < 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("init_int_read");
        INT = 1'b0;
        t = 0;
        while (vld_cnt < 1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("init_int_vld");
        if (wrt_cyc.size() >= 5) chk("read_after_idle", wrt_cyc[4] - wrt_cyc[3], LAT + 2);
        read_cmds_ok(4);

        // Directed table
        for (int i = 0; i < 4; i++) run_read(vt[i].b, {vt[i].p, vt[i].a});

        // INT held high: back-to-back reads
        base = cmd_log.size();
        n = vld_cnt;
        b = $urandom();
        push_read(b, model(b));
        b = $urandom();
        push_read(b, model(b));
        INT = 1'b1;
        t = 0;
        while (vld_cnt <= n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("hold_vld1");
        t = 0;
        while (cmd_log.size() <= base + 4 && t < 20) begin
            @(negedge clk);
            t++;
        end
        INT = 1'b0;
        if (t >= 20) timeout("retrig_start");
        else chk("retrig_gap", wrt_cyc[base+4] - last_vld_cyc, 2);
        t = 0;
        while (vld_cnt <= n + 1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("hold_vld2");
        read_cmds_ok(base);
        read_cmds_ok(base + 4);
        repeat (5) @(negedge clk);

        // Spurious done in IDLE
        w = cmd_log.size();
        n = vld_cnt;
        spur_n = 3;
        repeat (12) @(negedge clk);
        chk("spur_wrt", cmd_log.size(), w);
        chk("spur_vld", vld_cnt, n);
        chk("spur_ptch", ptch_rt, last_exp[31:16]);
        chk("spur_az", AZ, last_exp[15:0]);

        // Random reads against the reference model
        for (int i = 0; i < 20; i++) begin
            b = $urandom();
            run_read(b, model(b));
        end

        // Reset during RD_WT of byte 2, stray done afterwards
        base = cmd_log.size();
        n = vld_cnt;
        push_read({8'h44, 8'h33, 8'h22, 8'h11}, 32'h22114433);
        INT = 1'b1;
        t = 0;
        while (cmd_log.size() < base + 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("mid_rd_byte2");
        INT = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        chk("stray_ptch", ptch_rt, 16'h0000);
        chk("stray_az", AZ, 16'h0000);
        chk("stray_vld", vld_cnt, n);
        check_init(base + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
